// File: rtl/tsp_nn_route_planner.sv
// rtl/tsp_nn_route_planner.sv - nearest-neighbour tour planner for the 6-LED salesman demo
module tsp_nn_route_planner #(
    parameter int N_CITIES = 6,
    parameter int COORD_W  = 16,
    parameter int IDX_W    = 3,
    parameter int LEN_W    = COORD_W + 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               coord_we,
    input  logic [IDX_W-1:0]   coord_addr,
    input  logic [COORD_W-1:0] coord_wdata,
    input  logic               start,
    output logic               busy,
    output logic               next_valid,
    input  logic               next_ready,
    output logic [IDX_W-1:0]   next_city,
    output logic [COORD_W-1:0] next_dist,
    output logic               tour_done,
    output logic [LEN_W-1:0]   tour_len
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_SCAN, S_CLOSE} state_t;

    localparam logic [IDX_W:0]   N_EXT  = (IDX_W+1)'(N_CITIES);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_CITIES - 1);

    // Unsigned distance without wrap: always subtract the smaller from the larger.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t               state;
    state_t               state_nx;
    logic [COORD_W-1:0]   coord [N_CITIES];
    logic [N_CITIES-1:0]  visited;
    logic [IDX_W-1:0]     cur;
    logic [LEN_W-1:0]     acc;
    logic [IDX_W-1:0]     scan_i;
    logic [IDX_W-1:0]     best_idx;
    logic [COORD_W-1:0]   best_d;
    logic                 best_found;
    logic [LEN_W-1:0]     tour_len_q;

    logic                 accept;
    logic                 scan_last;
    logic [COORD_W-1:0]   cand_d;
    logic                 cand_take;
    logic [IDX_W-1:0]     sel_idx;
    logic [COORD_W-1:0]   sel_d;
    logic [LEN_W-1:0]     close_sum;
    logic                 coord_wr;

    assign accept    = (state == S_EMIT) && next_ready;
    assign scan_last = (scan_i == LAST_I);
    assign cand_d    = abs_diff(coord[scan_i], coord[cur]);
    // Strict less-than keeps the earliest (lowest index) candidate on ties.
    assign cand_take = !visited[scan_i] && (!best_found || (cand_d < best_d));
    assign sel_idx   = cand_take ? scan_i : best_idx;
    assign sel_d     = cand_take ? cand_d : best_d;
    assign close_sum = acc + LEN_W'(abs_diff(coord[cur], coord[0]));
    // A write coinciding with start is dropped so the tour sees a consistent map.
    assign coord_wr  = (state == S_IDLE) && coord_we && !start && ({1'b0, coord_addr} < N_EXT);

    assign busy       = (state != S_IDLE);
    assign next_valid = (state == S_EMIT);
    assign tour_done  = (state == S_CLOSE);
    assign tour_len   = tour_done ? close_sum : tour_len_q;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: emit, scan all candidates, repeat until every city has gone out.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_EMIT;
            S_EMIT:  if (accept) state_nx = (&visited) ? S_CLOSE : S_SCAN;
            S_SCAN:  if (scan_last) state_nx = S_EMIT;
            S_CLOSE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: coordinate store, visited mask, running best and tour accumulator.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_CITIES; i++) begin
                coord[i] <= COORD_W'(i + 1);
            end
            visited    <= '0;
            cur        <= '0;
            acc        <= '0;
            scan_i     <= '0;
            best_idx   <= '0;
            best_d     <= '0;
            best_found <= 1'b0;
            next_city  <= '0;
            next_dist  <= '0;
            tour_len_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        visited   <= {{(N_CITIES-1){1'b0}}, 1'b1};
                        cur       <= '0;
                        acc       <= '0;
                        next_city <= '0;
                        next_dist <= '0;
                    end else if (coord_wr) begin
                        coord[coord_addr] <= coord_wdata;
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        acc        <= acc + LEN_W'(next_dist);
                        cur        <= next_city;
                        scan_i     <= '0;
                        best_found <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (cand_take) begin
                        best_idx   <= scan_i;
                        best_d     <= cand_d;
                        best_found <= 1'b1;
                    end
                    scan_i <= scan_i + 1'b1;
                    if (scan_last) begin
                        visited[sel_idx] <= 1'b1;
                        next_city        <= sel_idx;
                        next_dist        <= sel_d;
                    end
                end
                S_CLOSE: begin
                    tour_len_q <= close_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tsp_nn_route_planner.sv
// tb/tb_tsp_nn_route_planner.sv - directed self-checking bench for tsp_nn_route_planner
module tb_tsp_nn_route_planner;

    localparam int N_CITIES = 6;
    localparam int COORD_W  = 16;
    localparam int IDX_W    = 3;
    localparam int LEN_W    = COORD_W + 3;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n;
    logic               coord_we;
    logic [IDX_W-1:0]   coord_addr;
    logic [COORD_W-1:0] coord_wdata;
    logic               start;
    logic               busy;
    logic               next_valid;
    logic               next_ready;
    logic [IDX_W-1:0]   next_city;
    logic [COORD_W-1:0] next_dist;
    logic               tour_done;
    logic [LEN_W-1:0]   tour_len;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_city [N_CITIES];
    int exp_dist [N_CITIES];
    int wcoord   [N_CITIES];

    tsp_nn_route_planner #(
        .N_CITIES(N_CITIES), .COORD_W(COORD_W), .IDX_W(IDX_W), .LEN_W(LEN_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .coord_we(coord_we), .coord_addr(coord_addr), .coord_wdata(coord_wdata),
        .start(start), .busy(busy),
        .next_valid(next_valid), .next_ready(next_ready),
        .next_city(next_city), .next_dist(next_dist),
        .tour_done(tour_done), .tour_len(tour_len)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic write_coords();
        for (int k = 0; k < N_CITIES; k++) begin
            coord_we    = 1'b1;
            coord_addr  = IDX_W'(k);
            coord_wdata = COORD_W'(wcoord[k]);
            @(posedge sys_clk); #1;
        end
        coord_we = 1'b0;
    endtask

    task automatic run_tour(input int t, input int exp_len, input bit stall,
                            input bit inject, input bit start_we);
        int lat;
        start = 1'b1;
        if (start_we) begin
            coord_we = 1'b1; coord_addr = 3'd0; coord_wdata = 16'd500;
        end
        @(posedge sys_clk); #1;
        start = 1'b0; coord_we = 1'b0;
        next_ready = !stall;
        chk($sformatf("T%0d busy_after_start", t), busy, 1);
        for (int k = 0; k < N_CITIES; k++) begin
            chk($sformatf("T%0d valid%0d", t, k), next_valid, 1);
            chk($sformatf("T%0d city%0d", t, k), next_city, exp_city[k]);
            chk($sformatf("T%0d dist%0d", t, k), next_dist, exp_dist[k]);
            if (stall) begin
                repeat (10) begin @(posedge sys_clk); #1; end
                chk($sformatf("T%0d hold_valid%0d", t, k), next_valid, 1);
                chk($sformatf("T%0d hold_city%0d", t, k), next_city, exp_city[k]);
                chk($sformatf("T%0d hold_dist%0d", t, k), next_dist, exp_dist[k]);
                next_ready = 1'b1;
            end
            @(posedge sys_clk); #1;
            next_ready = !stall;
            if (k < N_CITIES - 1) begin
                if (inject && k == 0) begin
                    coord_we = 1'b1; coord_addr = 3'd3; coord_wdata = 16'd100; start = 1'b1;
                end
                lat = 0;
                while (!next_valid && lat < 20) begin
                    @(posedge sys_clk); #1;
                    lat++;
                    coord_we = 1'b0; start = 1'b0;
                end
                chk($sformatf("T%0d latency%0d", t, k + 1), lat, N_CITIES);
            end
        end
        chk($sformatf("T%0d tour_done", t), tour_done, 1);
        chk($sformatf("T%0d busy_at_done", t), busy, 1);
        chk($sformatf("T%0d tour_len", t), tour_len, exp_len);
        @(posedge sys_clk); #1;
        chk($sformatf("T%0d done_drop", t), tour_done, 0);
        chk($sformatf("T%0d busy_drop", t), busy, 0);
        chk($sformatf("T%0d len_hold", t), tour_len, exp_len);
    endtask

    initial begin
        sys_rst_n = 1'b0; coord_we = 1'b0; coord_addr = '0; coord_wdata = '0;
        start = 1'b0; next_ready = 1'b1;
        repeat (3) @(posedge sys_clk); #1;
        chk("rst busy", busy, 0);
        chk("rst valid", next_valid, 0);
        chk("rst city", next_city, 0);
        chk("rst dist", next_dist, 0);
        chk("rst done", tour_done, 0);
        chk("rst len", tour_len, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // T1: reset coordinates 1..6
        exp_city = '{0, 1, 2, 3, 4, 5};
        exp_dist = '{0, 1, 1, 1, 1, 1};
        run_tour(1, 10, 1'b0, 1'b0, 1'b0);

        // T2: scattered coordinates
        wcoord = '{10, 0, 12, 3, 11, 20};
        write_coords();
        exp_city = '{0, 4, 2, 5, 3, 1};
        exp_dist = '{0, 1, 1, 8, 17, 3};
        run_tour(2, 40, 1'b0, 1'b0, 1'b0);

        // T3: ties and duplicates
        wcoord = '{5, 4, 6, 9, 9, 1};
        write_coords();
        exp_city = '{0, 1, 2, 3, 4, 5};
        exp_dist = '{0, 1, 2, 3, 0, 8};
        run_tour(3, 18, 1'b0, 1'b0, 1'b0);

        // T4: backpressure on T2 map, with a write colliding with start (dropped)
        wcoord = '{10, 0, 12, 3, 11, 20};
        write_coords();
        exp_city = '{0, 4, 2, 5, 3, 1};
        exp_dist = '{0, 1, 1, 8, 17, 3};
        run_tour(4, 40, 1'b1, 1'b0, 1'b1);

        // T5: write and start while busy are ignored
        wcoord = '{1, 2, 3, 4, 5, 6};
        write_coords();
        exp_city = '{0, 1, 2, 3, 4, 5};
        exp_dist = '{0, 1, 1, 1, 1, 1};
        run_tour(5, 10, 1'b0, 1'b1, 1'b0);

        // T6: reset mid-SCAN
        wcoord = '{10, 0, 12, 3, 11, 20};
        write_coords();
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; next_ready = 1'b1;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("T6 busy_pre_rst", busy, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("T6 rst busy", busy, 0);
        chk("T6 rst valid", next_valid, 0);
        chk("T6 rst city", next_city, 0);
        chk("T6 rst dist", next_dist, 0);
        chk("T6 rst done", tour_done, 0);
        chk("T6 rst len", tour_len, 0);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("T6 rst done_hold", tour_done, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        exp_city = '{0, 1, 2, 3, 4, 5};
        exp_dist = '{0, 1, 1, 1, 1, 1};
        run_tour(6, 10, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
